// File: rtl/ctrl_pkg.sv
// Shared types and constants for the control-signal pipeline.
// Used by ctrl_pipe and cond_check (COND_EXEC_EN build option).
package ctrl_pkg;

  // ARM condition field encodings
  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_t;

  // Bit positions inside the NZCV flags word
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Bit positions inside FlagWrite
  localparam int unsigned FW_NZ = 1;
  localparam int unsigned FW_CV = 0;

  // Execute-stage control fields (addresses are kept separately, they are RW wide)
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       pc_src;
    logic [1:0] flag_write;
    logic [3:0] cond;
  } ctrl_e_t;

endpackage

// File: rtl/ctrl_pipe_if.sv
// Decode-side inputs and stage-tagged outputs of the control pipeline.
// master: the core/hazard side driving Decode; slave: ctrl_pipe itself.
interface ctrl_pipe_if #(
  parameter int RW = 4
);
  logic          FlushE;
  logic [RW-1:0] RA1D, RA2D, WA3D;
  logic          RegWriteD, MemWriteD, MemtoRegD, BranchD, PCSrcD;
  logic [1:0]    FlagWriteD;
  logic [3:0]    CondD;
  logic [3:0]    ALUFlagsE;

  logic [RW-1:0] RA1E, RA2E, WA3E;
  logic          MemtoRegE, PCSrcE;
  logic          CondExE, BranchTakenE;
  logic [RW-1:0] WA3M, WA3W;
  logic          RegWriteM, MemWriteM, MemtoRegM, PCSrcM;
  logic          RegWriteW, MemtoRegW, PCSrcW;
  logic [3:0]    FlagsE;

  modport master (
    output FlushE, RA1D, RA2D, WA3D, RegWriteD, MemWriteD, MemtoRegD, BranchD, PCSrcD,
           FlagWriteD, CondD, ALUFlagsE,
    input  RA1E, RA2E, WA3E, MemtoRegE, PCSrcE, CondExE, BranchTakenE, WA3M, WA3W,
           RegWriteM, MemWriteM, MemtoRegM, PCSrcM, RegWriteW, MemtoRegW, PCSrcW, FlagsE
  );

  modport slave (
    input  FlushE, RA1D, RA2D, WA3D, RegWriteD, MemWriteD, MemtoRegD, BranchD, PCSrcD,
           FlagWriteD, CondD, ALUFlagsE,
    output RA1E, RA2E, WA3E, MemtoRegE, PCSrcE, CondExE, BranchTakenE, WA3M, WA3W,
           RegWriteM, MemWriteM, MemtoRegM, PCSrcM, RegWriteW, MemtoRegW, PCSrcW, FlagsE
  );
endinterface

// File: rtl/cond_check.sv
// Condition-field evaluation against NZCV flags.
// Instantiated by ctrl_pipe only when COND_EXEC_EN is defined.
module cond_check
  import ctrl_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  // Decode the condition field into pass/fail
  always_comb begin
    CondEx = 1'b0;
    case (cond_t'(Cond))
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = (n == v);
      COND_LT: CondEx = (n != v);
      COND_GT: CondEx = ~z & (n == v);
      COND_LE: CondEx = z | (n != v);
      COND_AL: CondEx = 1'b1;
      COND_NV: CondEx = 1'b0;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Control-signal pipeline D->E->M->W for the 5-stage ARM core, with NZCV
// flags and conditional execution evaluated in Execute.
// Build option: COND_EXEC_EN enables flags/condition logic; when undefined
// every instruction executes as AL and FlagsE stays 4'b0000.
// The interface instance must use the same RW as this module.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int RW = 4
) (
  input logic       clk,
  input logic       reset,
  ctrl_pipe_if.slave bus
);

  logic [RW-1:0] ra1_e, ra2_e, wa3_e, wa3_m, wa3_w;
  ctrl_e_t       ctl_e;
  logic          reg_write_m, mem_write_m, mem_to_reg_m, pc_src_m;
  logic          reg_write_w, mem_to_reg_w, pc_src_w;
  logic          cond_ex_e;
  logic [3:0]    flags_e;

  // E bank: reset or flush inserts a bubble with every enable cleared
  always_ff @(posedge clk) begin
    if (reset || bus.FlushE) begin
      ra1_e <= '0;
      ra2_e <= '0;
      wa3_e <= '0;
      ctl_e <= '0;
    end else begin
      ra1_e            <= bus.RA1D;
      ra2_e            <= bus.RA2D;
      wa3_e            <= bus.WA3D;
      ctl_e.reg_write  <= bus.RegWriteD;
      ctl_e.mem_write  <= bus.MemWriteD;
      ctl_e.mem_to_reg <= bus.MemtoRegD;
      ctl_e.branch     <= bus.BranchD;
      ctl_e.pc_src     <= bus.PCSrcD;
`ifdef COND_EXEC_EN
      ctl_e.flag_write <= bus.FlagWriteD;
      ctl_e.cond       <= bus.CondD;
`else
      ctl_e.flag_write <= '0;
      ctl_e.cond       <= '0;
`endif
    end
  end

`ifdef COND_EXEC_EN
  cond_check u_cond_check (
    .Cond   (ctl_e.cond),
    .Flags  (flags_e),
    .CondEx (cond_ex_e)
  );

  // Flags register: updated at the end of Execute only if the instruction passes
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_e <= '0;
    end else if (cond_ex_e) begin
      if (ctl_e.flag_write[FW_NZ])
        flags_e[FLAG_N:FLAG_Z] <= bus.ALUFlagsE[FLAG_N:FLAG_Z];
      if (ctl_e.flag_write[FW_CV])
        flags_e[FLAG_C:FLAG_V] <= bus.ALUFlagsE[FLAG_C:FLAG_V];
    end
  end
`else
  assign cond_ex_e = 1'b1;
  assign flags_e   = '0;

  logic unused_cond;
  assign unused_cond = ^{bus.FlagWriteD, bus.CondD, bus.ALUFlagsE, ctl_e.flag_write, ctl_e.cond};
`endif

  // M bank: write/branch enables gated by the Execute condition result
  always_ff @(posedge clk) begin
    if (reset) begin
      wa3_m        <= '0;
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      mem_to_reg_m <= 1'b0;
      pc_src_m     <= 1'b0;
    end else begin
      wa3_m        <= wa3_e;
      reg_write_m  <= ctl_e.reg_write & cond_ex_e;
      mem_write_m  <= ctl_e.mem_write & cond_ex_e;
      mem_to_reg_m <= ctl_e.mem_to_reg;
      pc_src_m     <= ctl_e.pc_src & cond_ex_e;
    end
  end

  // W bank: straight copy of M
  always_ff @(posedge clk) begin
    if (reset) begin
      wa3_w        <= '0;
      reg_write_w  <= 1'b0;
      mem_to_reg_w <= 1'b0;
      pc_src_w     <= 1'b0;
    end else begin
      wa3_w        <= wa3_m;
      reg_write_w  <= reg_write_m;
      mem_to_reg_w <= mem_to_reg_m;
      pc_src_w     <= pc_src_m;
    end
  end

  assign bus.RA1E         = ra1_e;
  assign bus.RA2E         = ra2_e;
  assign bus.WA3E         = wa3_e;
  assign bus.MemtoRegE    = ctl_e.mem_to_reg;
  assign bus.PCSrcE       = ctl_e.pc_src;
  assign bus.CondExE      = cond_ex_e;
  assign bus.BranchTakenE = ctl_e.branch & cond_ex_e;
  assign bus.FlagsE       = flags_e;
  assign bus.WA3M         = wa3_m;
  assign bus.RegWriteM    = reg_write_m;
  assign bus.MemWriteM    = mem_write_m;
  assign bus.MemtoRegM    = mem_to_reg_m;
  assign bus.PCSrcM       = pc_src_m;
  assign bus.WA3W         = wa3_w;
  assign bus.RegWriteW    = reg_write_w;
  assign bus.MemtoRegW    = mem_to_reg_w;
  assign bus.PCSrcW       = pc_src_w;

endmodule
